// File: rtl/irq_arbiter.sv
// Interrupt scheduler: per-source pending/config lanes, a max-priority tree, req/ack FSM and a nesting stack.
// Define IRQ_ARB_NEST_EN to allow nesting up to DepthMax levels; otherwise only one handler may be active.
module irq_arbiter_lane #(
  parameter int PrioWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 irq,
  input  logic                 cfg_we,
  input  logic [PrioWidth-1:0] cfg_prio,
  input  logic                 cfg_en,
  input  logic                 clr,
  input  logic [PrioWidth-1:0] level,
  output logic [PrioWidth-1:0] cand
);
  logic                 pend, en;
  logic [PrioWidth-1:0] prio;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      prio <= '0;
      en   <= 1'b0;
    end else begin
      // a new event in the ack cycle must not be lost
      pend <= irq | (pend & ~clr);
      if (cfg_we) begin
        prio <= cfg_prio;
        en   <= cfg_en;
      end
    end
  end

  assign cand = (pend && en && (prio > level)) ? prio : '0;
endmodule

module irq_arbiter #(
  parameter int NumSrc    = 8,
  parameter int PrioWidth = 4,
  parameter int DepthMax  = 4,
  localparam int IdW      = $clog2(NumSrc),
  localparam int DW       = $clog2(DepthMax+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NumSrc-1:0]    irq_i,
  input  logic                 cfg_we_i,
  input  logic [IdW-1:0]       cfg_idx_i,
  input  logic [PrioWidth-1:0] cfg_prio_i,
  input  logic                 cfg_en_i,
  output logic                 req_o,
  output logic [IdW-1:0]       req_id_o,
  output logic [PrioWidth-1:0] req_prio_o,
  input  logic                 ack_i,
  input  logic                 done_i,
  output logic [PrioWidth-1:0] level_o,
  output logic [DW-1:0]        depth_o
);
`ifdef IRQ_ARB_NEST_EN
  localparam logic [DW-1:0] EffDepth = DW'(DepthMax);
`else
  localparam logic [DW-1:0] EffDepth = DW'(1);
`endif

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [NumSrc-1:0][PrioWidth-1:0] cand;
  logic [PrioWidth-1:0] nval [1:2*NumSrc-1];
  logic [IdW-1:0]       nid  [1:2*NumSrc-1];
  logic [PrioWidth-1:0] stk  [0:(2**DW)-1];
  logic [DW-1:0]        depth_pop;
  logic                 ack_take;

  assign ack_take = (state == REQ) && ack_i;

  for (genvar k = 0; k < NumSrc; k++) begin : g_lane
    irq_arbiter_lane #(.PrioWidth(PrioWidth)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .irq      (irq_i[k]),
      .cfg_we   (cfg_we_i && (cfg_idx_i == IdW'(k))),
      .cfg_prio (cfg_prio_i),
      .cfg_en   (cfg_en_i),
      .clr      (ack_take && (req_id_o == IdW'(k))),
      .level    (level_o),
      .cand     (cand[k])
    );
    assign nval[NumSrc+k] = cand[k];
    assign nid[NumSrc+k]  = IdW'(k);
  end

  // heap-ordered tree: left child holds lower indices, so >= keeps the lowest index on ties
  for (genvar n = 1; n < NumSrc; n++) begin : g_tree
    assign nval[n] = (nval[2*n] >= nval[2*n+1]) ? nval[2*n] : nval[2*n+1];
    assign nid[n]  = (nval[2*n] >= nval[2*n+1]) ? nid[2*n]  : nid[2*n+1];
  end

  assign level_o = (depth_o == '0) ? '0 : stk[depth_o - DW'(1)];

  always_comb begin
    depth_pop = depth_o;
    if (done_i && (depth_o != '0)) depth_pop = depth_o - DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_o      <= 1'b0;
      req_id_o   <= '0;
      req_prio_o <= '0;
      depth_o    <= '0;
      for (int i = 0; i < 2**DW; i++) stk[i] <= '0;
    end else begin
      // pop before push so done+ack replaces the top
      if (ack_take) begin
        stk[depth_pop] <= req_prio_o;
        depth_o        <= depth_pop + DW'(1);
      end else begin
        depth_o <= depth_pop;
      end
      case (state)
        IDLE: if ((nval[1] != '0) && (depth_o < EffDepth)) begin
          req_id_o   <= nid[1];
          req_prio_o <= nval[1];
          req_o      <= 1'b1;
          state      <= REQ;
        end
        REQ: if (ack_i || (cfg_we_i && (cfg_idx_i == req_id_o))) begin
          req_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized bench for irq_arbiter against an array/queue reference model, plus directed scenarios.
module tb_irq_arbiter;
  localparam int N = 8, PW = 4, DM = 4, IW = 3, DW = 3;
`ifdef IRQ_ARB_NEST_EN
  localparam int EFF = DM;
`else
  localparam int EFF = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_i;
  logic          cfg_we_i, cfg_en_i, ack_i, done_i;
  logic [IW-1:0] cfg_idx_i;
  logic [PW-1:0] cfg_prio_i;
  logic          req_o;
  logic [IW-1:0] req_id_o;
  logic [PW-1:0] req_prio_o, level_o;
  logic [DW-1:0] depth_o;

  always #5 clk = ~clk;

  irq_arbiter #(.NumSrc(N), .PrioWidth(PW), .DepthMax(DM)) dut (
    .clk(clk), .reset(reset), .irq_i(irq_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
    .cfg_prio_i(cfg_prio_i), .cfg_en_i(cfg_en_i), .req_o(req_o), .req_id_o(req_id_o),
    .req_prio_o(req_prio_o), .ack_i(ack_i), .done_i(done_i), .level_o(level_o), .depth_o(depth_o)
  );

  int n_chk = 0, n_fail = 0;

  // reference model
  bit m_pend[N];
  int m_prio[N];
  bit m_en[N];
  int m_stk[$];
  bit m_req;
  int m_id, m_rp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_level();
    return (m_stk.size() == 0) ? 0 : m_stk[$];
  endfunction

  task automatic model_step();
    int best, bid, lvl, d0;
    if (reset) begin
      foreach (m_pend[k]) begin m_pend[k] = 0; m_prio[k] = 0; m_en[k] = 0; end
      m_stk.delete();
      m_req = 0; m_id = 0; m_rp = 0;
      return;
    end
    lvl = m_level(); d0 = m_stk.size();
    best = 0; bid = 0;
    for (int k = 0; k < N; k++)
      if (m_pend[k] && m_en[k] && m_prio[k] > lvl && m_prio[k] > best) begin best = m_prio[k]; bid = k; end
    for (int k = 0; k < N; k++)
      m_pend[k] = irq_i[k] || (m_pend[k] && !(m_req && ack_i && m_id == k));
    if (done_i && m_stk.size() > 0) void'(m_stk.pop_back());
    if (m_req && ack_i) m_stk.push_back(m_rp);
    if (!m_req) begin
      if (best != 0 && d0 < EFF) begin m_req = 1; m_id = bid; m_rp = best; end
    end else if (ack_i || (cfg_we_i && int'(cfg_idx_i) == m_id)) begin
      m_req = 0;
    end
    if (cfg_we_i) begin m_prio[cfg_idx_i] = cfg_prio_i; m_en[cfg_idx_i] = cfg_en_i; end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("req_o", req_o, m_req);
    chk("req_id_o", req_id_o, m_id);
    chk("req_prio_o", req_prio_o, m_rp);
    chk("level_o", level_o, m_level());
    chk("depth_o", depth_o, m_stk.size());
  endtask

  task automatic quiet();
    reset = 0; irq_i = '0; cfg_we_i = 0; cfg_idx_i = '0; cfg_prio_i = '0; cfg_en_i = 0;
    ack_i = 0; done_i = 0;
  endtask

  task automatic cfg(input int idx, input int p, input bit e);
    cfg_we_i = 1; cfg_idx_i = IW'(idx); cfg_prio_i = PW'(p); cfg_en_i = e;
    step();
    cfg_we_i = 0;
  endtask

  initial begin
    quiet();
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_req", req_o, 0);
    chk("rst_depth", depth_o, 0);

    // single source
    cfg(3, 5, 1);
    irq_i[3] = 1; step(); irq_i = '0; step();
    chk("single_req", req_o, 1);
    chk("single_id", req_id_o, 3);
    chk("single_prio", req_prio_o, 5);
    ack_i = 1; step(); ack_i = 0;
    chk("single_lvl", level_o, 5);
    chk("single_depth", depth_o, 1);
    done_i = 1; step(); done_i = 0;
    done_i = 1; step(); done_i = 0;
    chk("empty_done", depth_o, 0);

    // tie-break
    cfg(2, 7, 1); cfg(6, 7, 1);
    irq_i[2] = 1; irq_i[6] = 1; step(); irq_i = '0; step();
    chk("tie_id", req_id_o, 2);
    ack_i = 1; step(); ack_i = 0;
    step(); step();
    chk("tie_block", req_o, 0);
    done_i = 1; step(); done_i = 0; step();
    chk("tie_next", req_id_o, 6);
    chk("tie_req", req_o, 1);

    // reset during REQ
    reset = 1; step(); reset = 0;
    chk("rreq_req", req_o, 0);
    chk("rreq_id", req_id_o, 0);
    chk("rreq_prio", req_prio_o, 0);
    chk("rreq_lvl", level_o, 0);

    // randomized phase
    for (int k = 0; k < N; k++) cfg(k, $urandom_range(0, 15), $urandom_range(0, 7) != 0);
    for (int c = 0; c < 4000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      irq_i      = N'($urandom) & N'($urandom) & N'($urandom);
      cfg_we_i   = ($urandom_range(0, 9) == 0);
      cfg_idx_i  = (req_o && $urandom_range(0, 1)) ? req_id_o : IW'($urandom);
      cfg_prio_i = PW'($urandom);
      cfg_en_i   = ($urandom_range(0, 5) != 0);
      ack_i      = ($urandom_range(0, 2) == 0);
      done_i     = ($urandom_range(0, 4) == 0);
      step();
    end
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
